sha256_digest_ser: RTL

SHA256_DIGEST_SER -- requirements
Module: sha256_digest_ser

---
 rtl/sha256_digest_ser_if.sv | 20 ++
 rtl/sha256_digest_ser.sv | 97 +++++++++
 2 files changed

// File: rtl/sha256_digest_ser_if.sv
// Digest-in / word-out handshake bundle for the SHA256 digest serialiser.
// master is the surrounding system, slave is the serialiser itself.
interface sha256_digest_ser_if;
    logic         s_valid;
    logic [255:0] s_data;
    logic         d_valid;
    logic         d_ready;
    logic [31:0]  d_data;
    logic         d_last;

    modport master (
        output s_valid, s_data, d_ready,
        input  d_valid, d_data, d_last
    );

    modport slave (
        input  s_valid, s_data, d_ready,
        output d_valid, d_data, d_last
    );
endinterface

// File: rtl/sha256_digest_ser.sv
// Buffers 256-bit SHA256 digests and streams each as eight 32-bit words, MSW first; 1-cycle s_valid->d_valid.
// d_ready stalls the word stream; with the buffer full and no pop, an incoming digest is dropped and overflow sticks.
module sha256_digest_ser #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sha256_digest_ser_if.slave       bus,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [255:0]   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [2:0]     widx;
    logic           xfer;
    logic           pop;
    logic           wr_en;
    logic           drop;
    logic [LW-1:0]  level_nxt;
    logic [255:0]   head_sh;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (DEPTH == 1)
            return '0;
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign xfer  = bus.d_valid & bus.d_ready;
    assign pop   = xfer & (widx == 3'd7);
    // A pop frees the head slot in the same edge, so a full buffer can still take a digest.
    assign wr_en = bus.s_valid & ((level != LW'(DEPTH)) | pop);
    assign drop  = bus.s_valid & ~wr_en;

    always_comb begin
        level_nxt = level;
        case ({wr_en, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_en) state_nxt = SEND;
            SEND:    if (pop && (level_nxt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            widx     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            if (wr_en)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (xfer)
                widx <= widx + 3'd1;
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Storage is not reset; d_data is gated by d_valid so stale contents never leak.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= bus.s_data;
    end

    assign head_sh     = mem[rd_ptr] << {widx, 5'b0_0000};
    assign bus.d_valid = (state == SEND);
    assign bus.d_data  = bus.d_valid ? head_sh[255:224] : 32'h0;
    assign bus.d_last  = bus.d_valid & (widx == 3'd7);

    a_valid_level: assert property (@(posedge clk) disable iff (!reset_n)
        bus.d_valid == (level != '0));
    a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.d_valid && !bus.d_ready) |=> (bus.d_valid && $stable(bus.d_data) && $stable(bus.d_last)));
endmodule
